// File: rtl/pdl_sensor_ctrl.sv
// pdl_sensor_ctrl: calibration sweep and alarm filter for a bank of
// delay-line clock-glitch sensors sharing one delay tap.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// IDLE       | sensors off, waiting for cal_start
// SETTLE     | tap just changed; wait SETTLE cycles, alarms ignored
// SAMPLE     | observe alarms for CAL_SAMPLES cycles at the current tap
// SETTLE_MON | final tap applied; wait SETTLE cycles, then enter MONITOR
// MONITOR    | windowed alarm filter drives alarm_irq / alarm_src
// FAIL       | calibration found no usable tap; sensors off
module pdl_sensor_ctrl #(
    parameter int N_SENS      = 4,
    parameter int TAP_W       = 4,
    parameter int SETTLE      = 8,
    parameter int CAL_SAMPLES = 16,
    parameter int MARGIN      = 2,
    parameter int WIN         = 32,
    parameter int THRESH      = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cal_start,
    input  logic              irq_clr,
    input  logic [N_SENS-1:0] sens_alarm,
    output logic [N_SENS-1:0] sens_en,
    output logic [TAP_W-1:0]  tap_sel,
    output logic              busy,
    output logic              cal_done,
    output logic              cal_fail,
    output logic              alarm_irq,
    output logic [N_SENS-1:0] alarm_src
);

    localparam int TMR_MAX = (SETTLE > CAL_SAMPLES) ? SETTLE : CAL_SAMPLES;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
    localparam int WIN_W   = (WIN > 1) ? $clog2(WIN) : 1;
    localparam int CNT_W   = $clog2(THRESH + 1);

    localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE - 1);
    localparam logic [TMR_W-1:0] SAMPLE_LD = TMR_W'(CAL_SAMPLES - 1);
    localparam logic [TAP_W-1:0] TAP_MAX   = {TAP_W{1'b1}};
    localparam logic [TAP_W-1:0] MARGIN_T  = TAP_W'(MARGIN);
    localparam logic [WIN_W-1:0] WIN_LAST  = WIN_W'(WIN - 1);
    localparam logic [CNT_W-1:0] THRESH_T  = CNT_W'(THRESH);
    localparam logic [CNT_W-1:0] THRESH_M1 = CNT_W'(THRESH - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETTLE_ST,
        SAMPLE,
        SETTLE_MON,
        MONITOR,
        FAIL
    } state_t;

    state_t             state_q, state_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic [TAP_W-1:0]   tap_q, tap_d;
    logic               hit_q, hit_d;
    logic               done_q, done_d;
    logic               fail_q, fail_d;

    logic [WIN_W-1:0]   win_cnt_q, win_cnt_d;
    logic [CNT_W-1:0]   alarm_cnt_q, alarm_cnt_d;
    logic [N_SENS-1:0]  win_src_q, win_src_d;
    logic               irq_q, irq_d;
    logic [N_SENS-1:0]  src_q, src_d;

    logic               alarm_any;
    logic               hit_now;
    logic               mon;
    logic               wrap;
    logic [CNT_W-1:0]   cnt_base;
    logic [N_SENS-1:0]  src_base;
    logic               trig;

    assign alarm_any = |sens_alarm;

    // Calibration state register and its datapath (tap, phase timer, hit flag).
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            tmr_q   <= '0;
            tap_q   <= '0;
            hit_q   <= 1'b0;
            done_q  <= 1'b0;
            fail_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            tap_q   <= tap_d;
            hit_q   <= hit_d;
            done_q  <= done_d;
            fail_q  <= fail_d;
        end
    end

    // Next-state logic: sweep taps upward until one trips, then back off by MARGIN.
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        tap_d   = tap_q;
        hit_d   = hit_q;
        done_d  = done_q;
        fail_d  = fail_q;
        hit_now = hit_q | alarm_any;

        if (cal_start) begin
            // Restart is allowed from any state, including mid-sweep.
            state_d = SETTLE_ST;
            tmr_d   = SETTLE_LD;
            tap_d   = '0;
            hit_d   = 1'b0;
            done_d  = 1'b0;
            fail_d  = 1'b0;
        end else begin
            unique case (state_q)
                SETTLE_ST, SETTLE_MON: begin
                    if (tmr_q == '0) begin
                        state_d = (state_q == SETTLE_MON) ? MONITOR : SAMPLE;
                        tmr_d   = (state_q == SETTLE_MON) ? '0 : SAMPLE_LD;
                        hit_d   = 1'b0;
                    end else begin
                        tmr_d = tmr_q - TMR_W'(1);
                    end
                end
                SAMPLE: begin
                    if (tmr_q == '0) begin
                        hit_d = 1'b0;
                        if (!hit_now) begin
                            if (tap_q != TAP_MAX) begin
                                tap_d   = tap_q + TAP_W'(1);
                                tmr_d   = SETTLE_LD;
                                state_d = SETTLE_ST;
                            end else begin
                                fail_d  = 1'b1;
                                state_d = FAIL;
                            end
                        end else if (tap_q <= MARGIN_T) begin
                            // First failing tap too low to leave MARGIN of headroom.
                            fail_d  = 1'b1;
                            state_d = FAIL;
                        end else begin
                            tap_d   = tap_q - MARGIN_T;
                            done_d  = 1'b1;
                            tmr_d   = SETTLE_LD;
                            state_d = SETTLE_MON;
                        end
                    end else begin
                        tmr_d = tmr_q - TMR_W'(1);
                        hit_d = hit_now;
                    end
                end
                default: ;
            endcase
        end
    end

    // Window filter: count alarm cycles per window, trigger on reaching THRESH.
    always_comb begin
        mon      = (state_q == MONITOR);
        wrap     = (win_cnt_q == WIN_LAST);
        // On the wrap cycle the window restarts, so this cycle's alarm opens the new one.
        cnt_base = wrap ? '0 : alarm_cnt_q;
        src_base = wrap ? '0 : win_src_q;
        trig     = mon && alarm_any && (cnt_base == THRESH_M1);

        win_cnt_d   = '0;
        alarm_cnt_d = '0;
        win_src_d   = '0;
        if (mon) begin
            win_cnt_d   = wrap ? '0 : win_cnt_q + WIN_W'(1);
            alarm_cnt_d = (alarm_any && cnt_base != THRESH_T) ? cnt_base + CNT_W'(1) : cnt_base;
            win_src_d   = src_base | sens_alarm;
        end

        irq_d = irq_q;
        src_d = src_q;
        if (cal_start) begin
            irq_d = 1'b0;
            src_d = '0;
        end else if (trig) begin
            // A trigger beats a simultaneous irq_clr; the clear only drops old sources.
            irq_d = 1'b1;
            src_d = (irq_clr ? '0 : src_q) | src_base | sens_alarm;
        end else if (irq_clr) begin
            irq_d = 1'b0;
            src_d = '0;
        end
    end

    // Monitor window registers and sticky interrupt flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            win_cnt_q   <= '0;
            alarm_cnt_q <= '0;
            win_src_q   <= '0;
            irq_q       <= 1'b0;
            src_q       <= '0;
        end else begin
            win_cnt_q   <= win_cnt_d;
            alarm_cnt_q <= alarm_cnt_d;
            win_src_q   <= win_src_d;
            irq_q       <= irq_d;
            src_q       <= src_d;
        end
    end

    // Output decode straight from registered state.
    always_comb begin
        busy      = (state_q == SETTLE_ST) || (state_q == SAMPLE) || (state_q == SETTLE_MON);
        sens_en   = ((state_q == IDLE) || (state_q == FAIL)) ? '0 : '1;
        tap_sel   = tap_q;
        cal_done  = done_q;
        cal_fail  = fail_q;
        alarm_irq = irq_q;
        alarm_src = src_q;
    end

endmodule

// File: tb/tb_pdl_sensor_ctrl.sv
// Directed testbench for pdl_sensor_ctrl: reset, calibration sweep, failures,
// window filter, interrupt clear and calibration restart.
module tb_pdl_sensor_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       cal_start;
    logic       irq_clr;
    logic [3:0] sens_alarm;
    logic [3:0] sens_en;
    logic [3:0] tap_sel;
    logic       busy;
    logic       cal_done;
    logic       cal_fail;
    logic       alarm_irq;
    logic [3:0] alarm_src;

    int n_checks = 0;
    int n_fail   = 0;
    int k        = 0;

    pdl_sensor_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .cal_start  (cal_start),
        .irq_clr    (irq_clr),
        .sens_alarm (sens_alarm),
        .sens_en    (sens_en),
        .tap_sel    (tap_sel),
        .busy       (busy),
        .cal_done   (cal_done),
        .cal_fail   (cal_fail),
        .alarm_irq  (alarm_irq),
        .alarm_src  (alarm_src)
    );

    always #5 clk = ~clk;

    // Idle monitor cycles until cycle index k reaches target.
    task automatic run_to(input int target);
        sens_alarm = 4'b0;
        irq_clr    = 1'b0;
        while (k < target) begin
            @(negedge clk);
            k++;
        end
    endtask

    // One monitor cycle with the given alarm bits and irq_clr.
    task automatic pulse(input logic [3:0] a, input logic c);
        sens_alarm = a;
        irq_clr    = c;
        @(negedge clk);
        k++;
        sens_alarm = 4'b0;
        irq_clr    = 1'b0;
    endtask

    task automatic test_reset;
        logic [14:0] outs;
        rst = 1'b1; cal_start = 1'b0; irq_clr = 1'b0; sens_alarm = 4'hF;
        repeat (2) @(negedge clk);
        outs = {sens_en, tap_sel, busy, cal_done, cal_fail, alarm_irq, alarm_src};
        if (outs !== 15'h0) begin
            $display("FAIL reset_outputs: got %h expected 0", outs); n_fail++;
        end
        n_checks++;
        rst = 1'b0;
        repeat (5) @(negedge clk);
        outs = {sens_en, tap_sel, busy, cal_done, cal_fail, alarm_irq, alarm_src};
        if (outs !== 15'h0) begin
            $display("FAIL idle_hold: got %h expected 0", outs); n_fail++;
        end
        n_checks++;
        sens_alarm = 4'b0;
    endtask

    task automatic test_clean_cal;
        int n, m;
        logic [3:0] max_tap;
        logic busy_drop;
        cal_start = 1'b1;
        @(negedge clk);
        cal_start = 1'b0;
        n = 1;
        if (busy !== 1'b1 || tap_sel !== 4'd0 || sens_en !== 4'hF) begin
            $display("FAIL cal_entry: busy=%b tap=%0d en=%h expected 1 0 f", busy, tap_sel, sens_en);
            n_fail++;
        end
        n_checks++;
        max_tap = 4'd0; busy_drop = 1'b0;
        while (cal_done !== 1'b1 && n < 400) begin
            sens_alarm = (tap_sel >= 4'd9) ? 4'b0001 : 4'b0000;
            if (tap_sel > max_tap) max_tap = tap_sel;
            if (busy !== 1'b1) busy_drop = 1'b1;
            @(negedge clk);
            n++;
        end
        sens_alarm = 4'b0;
        if (n != 241) begin
            $display("FAIL cal_done_latency: got %0d expected 241", n); n_fail++;
        end
        n_checks++;
        if (max_tap !== 4'd9) begin
            $display("FAIL sweep_max_tap: got %0d expected 9", max_tap); n_fail++;
        end
        n_checks++;
        if (tap_sel !== 4'd7 || busy_drop !== 1'b0 || busy !== 1'b1) begin
            $display("FAIL cal_result: tap=%0d busy_drop=%b busy=%b expected 7 0 1", tap_sel, busy_drop, busy);
            n_fail++;
        end
        n_checks++;
        m = 0;
        while (busy === 1'b1 && m < 50) begin
            @(negedge clk);
            m++;
        end
        if (m != 8) begin
            $display("FAIL settle_mon_len: got %0d expected 8", m); n_fail++;
        end
        n_checks++;
        if (sens_en !== 4'hF || cal_done !== 1'b1 || alarm_irq !== 1'b0) begin
            $display("FAIL monitor_entry: en=%h done=%b irq=%b expected f 1 0", sens_en, cal_done, alarm_irq);
            n_fail++;
        end
        n_checks++;
        k = 0;
    endtask

    task automatic test_filter;
        run_to(2);  pulse(4'b0100, 1'b0);
        run_to(5);  pulse(4'b0100, 1'b0);
        run_to(33); pulse(4'b0100, 1'b0);
        run_to(36); pulse(4'b0100, 1'b0);
        run_to(60);
        if (alarm_irq !== 1'b0) begin
            $display("FAIL no_irq_split_windows: got %b expected 0", alarm_irq); n_fail++;
        end
        n_checks++;
        run_to(66); pulse(4'b0100, 1'b0);
        run_to(68); pulse(4'b0001, 1'b0);
        if (alarm_irq !== 1'b0) begin
            $display("FAIL no_irq_two_alarms: got %b expected 0", alarm_irq); n_fail++;
        end
        n_checks++;
        run_to(70); pulse(4'b0100, 1'b0);
        if (alarm_irq !== 1'b1 || alarm_src !== 4'b0101) begin
            $display("FAIL irq_third_alarm: irq=%b src=%b expected 1 0101", alarm_irq, alarm_src);
            n_fail++;
        end
        n_checks++;
    endtask

    task automatic test_clear;
        run_to(72); pulse(4'b0000, 1'b1);
        if (alarm_irq !== 1'b0 || alarm_src !== 4'b0000 || cal_done !== 1'b1) begin
            $display("FAIL irq_clr_alone: irq=%b src=%b done=%b expected 0 0000 1", alarm_irq, alarm_src, cal_done);
            n_fail++;
        end
        n_checks++;
        run_to(98); pulse(4'b0010, 1'b0);
        run_to(99); pulse(4'b0010, 1'b0);
        pulse(4'b0010, 1'b1);
        if (alarm_irq !== 1'b1 || alarm_src !== 4'b0010) begin
            $display("FAIL set_wins_over_clr: irq=%b src=%b expected 1 0010", alarm_irq, alarm_src);
            n_fail++;
        end
        n_checks++;
        pulse(4'b0000, 1'b1);
        if (alarm_irq !== 1'b0) begin
            $display("FAIL irq_clr_after_set: got %b expected 0", alarm_irq); n_fail++;
        end
        n_checks++;
        run_to(127); pulse(4'b1000, 1'b0);
        run_to(130); pulse(4'b0001, 1'b0);
        if (alarm_irq !== 1'b0) begin
            $display("FAIL wrap_two_alarms: got %b expected 0", alarm_irq); n_fail++;
        end
        n_checks++;
        pulse(4'b0001, 1'b0);
        if (alarm_irq !== 1'b1 || alarm_src !== 4'b1001) begin
            $display("FAIL wrap_alarm_counts: irq=%b src=%b expected 1 1001", alarm_irq, alarm_src);
            n_fail++;
        end
        n_checks++;
    endtask

    task automatic test_restart;
        int n;
        sens_alarm = 4'b0;
        cal_start = 1'b1;
        @(negedge clk);
        cal_start = 1'b0;
        n = 1;
        if (alarm_irq !== 1'b0 || alarm_src !== 4'b0 || cal_done !== 1'b0 || busy !== 1'b1) begin
            $display("FAIL start_clears: irq=%b src=%b done=%b busy=%b expected 0 0000 0 1",
                     alarm_irq, alarm_src, cal_done, busy);
            n_fail++;
        end
        n_checks++;
        while (n < 131) begin
            @(negedge clk);
            n++;
        end
        if (tap_sel !== 4'd5 || busy !== 1'b1) begin
            $display("FAIL tap5_reached: tap=%0d busy=%b expected 5 1", tap_sel, busy); n_fail++;
        end
        n_checks++;
        cal_start = 1'b1;
        @(negedge clk);
        cal_start = 1'b0;
        if (tap_sel !== 4'd0 || busy !== 1'b1) begin
            $display("FAIL restart_in_sample: tap=%0d busy=%b expected 0 1", tap_sel, busy); n_fail++;
        end
        n_checks++;
    endtask

    task automatic test_fail_never;
        int n;
        n = 1;
        while (cal_fail !== 1'b1 && n < 500) begin
            sens_alarm = 4'b0;
            @(negedge clk);
            n++;
        end
        if (n != 385) begin
            $display("FAIL never_trip_latency: got %0d expected 385", n); n_fail++;
        end
        n_checks++;
        if (tap_sel !== 4'd15 || sens_en !== 4'h0 || busy !== 1'b0 || cal_done !== 1'b0) begin
            $display("FAIL never_trip_state: tap=%0d en=%h busy=%b done=%b expected 15 0 0 0",
                     tap_sel, sens_en, busy, cal_done);
            n_fail++;
        end
        n_checks++;
    endtask

    task automatic test_fail_early;
        int n;
        cal_start = 1'b1;
        @(negedge clk);
        cal_start = 1'b0;
        n = 1;
        if (cal_fail !== 1'b0) begin
            $display("FAIL fail_cleared_on_start: got %b expected 0", cal_fail); n_fail++;
        end
        n_checks++;
        while (cal_fail !== 1'b1 && n < 200) begin
            sens_alarm = (tap_sel >= 4'd1) ? 4'b0010 : 4'b0000;
            @(negedge clk);
            n++;
        end
        sens_alarm = 4'b0;
        if (n != 49 || sens_en !== 4'h0 || cal_done !== 1'b0) begin
            $display("FAIL low_tap_fail: cycles=%0d en=%h done=%b expected 49 0 0", n, sens_en, cal_done);
            n_fail++;
        end
        n_checks++;
    endtask

    task automatic test_reset_mid;
        logic [14:0] outs;
        cal_start = 1'b1;
        @(negedge clk);
        cal_start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        outs = {sens_en, tap_sel, busy, cal_done, cal_fail, alarm_irq, alarm_src};
        if (outs !== 15'h0) begin
            $display("FAIL reset_mid_cal: got %h expected 0", outs); n_fail++;
        end
        n_checks++;
    endtask

    initial begin
        rst = 1'b1; cal_start = 1'b0; irq_clr = 1'b0; sens_alarm = 4'b0;
        test_reset;
        test_clean_cal;
        test_filter;
        test_clear;
        test_restart;
        test_fail_never;
        test_fail_early;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
